// File: rtl/vga_pattern_sequencer_pkg.sv
// Shared definitions for the VGA pattern sequencer: sequencer states, pattern
// encodings, visible-area limits and the default band position.
package vga_pattern_sequencer_pkg;

  typedef enum logic {
    ST_MANUAL,
    ST_AUTO
  } seq_state_e;

  typedef enum logic [2:0] {
    PAT_RED     = 3'd0,
    PAT_GREEN   = 3'd1,
    PAT_BLUE    = 3'd2,
    PAT_WHITE   = 3'd3,
    PAT_BARS    = 3'd4,
    PAT_SCROLL  = 3'd5
  } pattern_e;

  localparam logic [9:0] V_TOP        = 10'd34;
  localparam logic [9:0] V_BOT        = 10'd514;
  localparam logic [9:0] BAND_TOP_DEF = 10'd100;
  localparam logic [9:0] BAND_BOT_DEF = 10'd400;

  function automatic logic [2:0] next_pattern(input logic [2:0] cur, input logic [2:0] last);
    return (cur == last) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/vga_pattern_sequencer_key_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a stability counter.
// Emits a single-cycle pulse when the debounced level falls (key pressed).
module vga_pattern_sequencer_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          key_level;
  logic [CW-1:0] stable_cnt;

  // The level only follows the synchronised input after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      key_level  <= 1'b1;
      stable_cnt <= '0;
      key_press  <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      key_press <= 1'b0;
      if (sync2 == key_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        stable_cnt <= '0;
        key_level  <= sync2;
        key_press  <= ~sync2;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous pattern/band controller; all visible outputs change only in
// the cycle after a vys falling edge so the colour logic never tears mid-frame.
module vga_pattern_sequencer
  import vga_pattern_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_PATTERNS    = 6,
  parameter int AUTO_FRAMES     = 120,
  parameter int BAND_H          = 300,
  parameter int SCROLL_STEP     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vys,
  input  logic       key_n,
  input  logic       auto_en,
  output logic [2:0] pattern_sel,
  output logic [9:0] band_top,
  output logic [9:0] band_bot,
  output logic       frame_tick
);

  localparam logic [2:0] LAST_PAT = 3'(NUM_PATTERNS - 1);
  localparam logic [9:0] TOP_MAX  = 10'(int'(V_BOT) - BAND_H);
  localparam logic [9:0] STEP     = 10'(SCROLL_STEP);
  localparam logic [9:0] BAND     = 10'(BAND_H);
  localparam int FCW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(AUTO_FRAMES - 1);

  logic           key_press;
  logic           vys_d;
  logic           pending;
  logic           scroll_down;
  logic           boundary;
  logic           advance;
  logic [2:0]     new_pat;
  logic [9:0]     top_next;
  logic           down_next;
  logic [FCW-1:0] frame_cnt;
  seq_state_e     state;

  vga_pattern_sequencer_key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk      (clk),
    .reset    (reset),
    .key_n    (key_n),
    .key_press(key_press)
  );

  // A press arriving in the boundary cycle itself still counts for that boundary.
  always_comb begin
    boundary  = vys_d & ~vys;
    advance   = pending | key_press | ((state == ST_AUTO) && (frame_cnt == FC_LAST));
    new_pat   = advance ? next_pattern(pattern_sel, LAST_PAT) : pattern_sel;
    top_next  = band_top;
    down_next = scroll_down;
    if (new_pat != LAST_PAT) begin
      top_next = BAND_TOP_DEF;
    end else if (advance) begin
      top_next  = V_TOP;
      down_next = 1'b1;
    end else if (scroll_down) begin
      if (band_top >= TOP_MAX - STEP) begin
        top_next  = TOP_MAX;
        down_next = 1'b0;
      end else begin
        top_next = band_top + STEP;
      end
    end else begin
      if (band_top <= V_TOP + STEP) begin
        top_next  = V_TOP;
        down_next = 1'b1;
      end else begin
        top_next = band_top - STEP;
      end
    end
  end

  // auto_en is only honoured at a boundary; the frame counter idles at 0 in MANUAL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vys_d       <= 1'b0;
      frame_tick  <= 1'b0;
      pending     <= 1'b0;
      state       <= ST_MANUAL;
      frame_cnt   <= '0;
      pattern_sel <= PAT_RED;
      band_top    <= BAND_TOP_DEF;
      band_bot    <= BAND_BOT_DEF;
      scroll_down <= 1'b1;
    end else begin
      vys_d      <= vys;
      frame_tick <= boundary;
      if (boundary) begin
        pending     <= 1'b0;
        pattern_sel <= new_pat;
        band_top    <= top_next;
        band_bot    <= top_next + BAND;
        scroll_down <= down_next;
        state       <= auto_en ? ST_AUTO : ST_MANUAL;
        if (advance || !auto_en || (state == ST_MANUAL)) begin
          frame_cnt <= '0;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else if (key_press) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench: frame-level stimulus (presses, glitches, auto mode) checked
// against a per-frame behavioural model of pattern selection and band scrolling.
module tb_vga_pattern_sequencer;

  localparam int DEB        = 16;
  localparam int AF         = 3;
  localparam int NP         = 6;
  localparam int BAND_H     = 300;
  localparam int VTOP       = 34;
  localparam int VBOT       = 514;
  localparam int STEP       = 2;
  localparam int FRAME_HIGH = 150;
  localparam int FRAME_LOW  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vys = 1'b1;
  logic       key_n = 1'b1;
  logic       auto_en = 1'b0;
  logic [2:0] pattern_sel;
  logic [9:0] band_top;
  logic [9:0] band_bot;
  logic       frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int tickCount = 0;

  int mPat;
  int mTop;
  int mDown;
  int mAuto;
  int mCnt;

  vga_pattern_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_PATTERNS   (NP),
    .AUTO_FRAMES    (AF),
    .BAND_H         (BAND_H),
    .SCROLL_STEP    (STEP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vys        (vys),
    .key_n      (key_n),
    .auto_en    (auto_en),
    .pattern_sel(pattern_sel),
    .band_top   (band_top),
    .band_bot   (band_bot),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (frame_tick) tickCount++;
    end
  endtask

  task automatic modelReset();
    mPat  = 0;
    mTop  = 100;
    mDown = 1;
    mAuto = 0;
    mCnt  = 0;
  endtask

  // One frame boundary of the reference: decide advance, move pattern, then band.
  task automatic modelBoundary(input int presses, input int autoEn);
    int adv;
    adv = (presses > 0) || (mAuto != 0 && mCnt == AF - 1);
    if (adv != 0) begin
      mPat = (mPat + 1) % NP;
      mCnt = 0;
    end else if (mAuto != 0) begin
      mCnt++;
    end
    if (autoEn == 0 || mAuto == 0) mCnt = 0;
    mAuto = autoEn;
    if (mPat != NP - 1) begin
      mTop = 100;
    end else if (adv != 0) begin
      mTop  = VTOP;
      mDown = 1;
    end else if (mDown != 0) begin
      mTop = (mTop + STEP < VBOT - BAND_H) ? mTop + STEP : VBOT - BAND_H;
      if (mTop == VBOT - BAND_H) mDown = 0;
    end else begin
      mTop = (mTop - STEP > VTOP) ? mTop - STEP : VTOP;
      if (mTop == VTOP) mDown = 1;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".pattern"}, int'(pattern_sel), mPat);
    checkOutput({tag, ".top"}, int'(band_top), mTop);
    checkOutput({tag, ".bot"}, int'(band_bot), mTop + BAND_H);
  endtask

  // Drives one full frame: optional glitch, clean presses, then the vys low period.
  task automatic applyStimulus(input int presses, input int glitch, input int autoEn);
    int used;
    used      = 10;
    tickCount = 0;
    auto_en   = (autoEn != 0);
    stepCycles(10);
    if (glitch != 0) begin
      key_n = 1'b0;
      stepCycles(5);
      key_n = 1'b1;
      stepCycles(25);
      used += 30;
    end
    for (int i = 0; i < presses; i++) begin
      key_n = 1'b0;
      stepCycles(22);
      key_n = 1'b1;
      stepCycles(25);
      used += 47;
    end
    stepCycles(FRAME_HIGH - used);
    checkOutput("noEarlyTick", tickCount, 0);
    vys = 1'b0;
    stepCycles(1);
    checkOutput("frameTick", int'(frame_tick), 1);
    modelBoundary(presses, autoEn);
    checkModel("frame");
    stepCycles(FRAME_LOW - 1);
    vys = 1'b1;
    checkOutput("tickCount", tickCount, 1);
  endtask

  task automatic doReset();
    reset = 1'b0;
    stepCycles(3);
    reset = 1'b1;
    modelReset();
  endtask

  initial begin
    int autoExp[7];
    int guard;
    autoExp = '{0, 0, 0, 1, 1, 1, 2};
    modelReset();

    // Reset held while vys and the key wiggle: nothing may move.
    tickCount = 0;
    for (int i = 0; i < 6; i++) begin
      vys = ~vys;
      key_n = ~key_n;
      stepCycles(7);
    end
    vys   = 1'b1;
    key_n = 1'b1;
    stepCycles(30);
    checkOutput("rst.tick", tickCount, 0);
    checkModel("rst");
    reset = 1'b1;
    stepCycles(5);

    applyStimulus(1, 0, 0);
    checkOutput("press.pattern", int'(pattern_sel), 1);
    applyStimulus(0, 1, 0);
    checkOutput("glitch.pattern", int'(pattern_sel), 1);
    applyStimulus(2, 0, 0);
    checkOutput("twoPress.pattern", int'(pattern_sel), 2);

    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput("autoSeq", int'(pattern_sel), autoExp[i]);
    end
    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);

    repeat (40) begin
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    // Walk to the scroll pattern and follow the band through a full bounce.
    applyStimulus(0, 0, 0);
    guard = 0;
    while (mPat != NP - 2 && guard < 12) begin
      applyStimulus(1, 0, 0);
      guard++;
    end
    checkOutput("reachPat4", mPat, NP - 2);
    applyStimulus(1, 0, 0);
    checkOutput("scroll.enterTop", int'(band_top), VTOP);
    repeat (92) applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("wrap.pattern", int'(pattern_sel), 0);
    checkOutput("wrap.top", int'(band_top), 100);

    // Re-enter scroll, then reset in the middle of a frame.
    for (int i = 0; i < NP - 1; i++) applyStimulus(1, 0, 0);
    repeat (4) applyStimulus(0, 0, 0);
    stepCycles(30);
    reset = 1'b0;
    #1;
    checkOutput("midRst.pattern", int'(pattern_sel), 0);
    checkOutput("midRst.top", int'(band_top), 100);
    checkOutput("midRst.bot", int'(band_bot), 400);
    checkOutput("midRst.tick", int'(frame_tick), 0);
    stepCycles(3);
    reset = 1'b1;
    modelReset();
    applyStimulus(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
